tri_bus_arbiter: RTL
====================

TRI_BUS_ARBITER -- requirements
Module: tri_bus_arbiter

Interface
REQ-001 Parameter N, default 4: number of requesters sharing one tri-state bus.
REQ-002 Parameter MAX_HOLD, default 8: maximum consecutive grant cycles per tenure.
REQ-003 Parameter TURN_CYCLES, default 1: dead cycles with no driver between tenures.
REQ-004 iClk  input  1  single clock; all state changes on its rising edge.
REQ-005 iRst_n  input  1  asynchronous, active-low reset.
REQ-006 iReq  input  N  per-requester bus request, level-sensitive, held high while the bus is wanted.
REQ-007 oGnt  output  N  one-hot grant, registered; at most one bit high.
REQ-008 oEna  output  N  tri-state enables, active-high, bit-identical to oGnt, one per bus driver.
REQ-009 oOwner  output  clog2(N)  index of current grantee; 0 when no grant is active.
REQ-010 oBusy  output  1  high in GRANT and TURN states.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, GRANT, TURN.
REQ-012 IDLE: if any iReq bit is high, the block SHALL select a winner by round-robin from pointer ptr and enter GRANT on the next edge; otherwise it stays in IDLE.
REQ-013 Round-robin: the winner SHALL be the first requesting index at or after ptr, wrapping from N-1 to 0.
REQ-014 Latency: iReq rising in cycle t while in IDLE SHALL give oGnt high in cycle t+1.
REQ-015 GRANT: hold counter hcnt SHALL count from 0 and increment once per GRANT cycle.
REQ-016 GRANT SHALL exit to TURN on the edge where iReq[owner] is low, or where hcnt equals MAX_HOLD-1; when both hold, the single exit to TURN SHALL occur.
REQ-017 On GRANT exit, ptr SHALL become (owner+1) mod N, wrapping from N-1 to 0.
REQ-018 In TURN, oGnt and oEna SHALL be all-zero for exactly TURN_CYCLES cycles.
REQ-019 At TURN end: any request SHALL arbitrate as in IDLE and enter GRANT directly; otherwise the FSM SHALL enter IDLE.
REQ-020 Requests from non-owners during GRANT or TURN SHALL be ignored until arbitration.
REQ-021 A requester released by MAX_HOLD expiry that still requests SHALL be regranted only when no other index requests.
REQ-022 oGnt SHALL never change directly from one one-hot value to a different one-hot value; an all-zero gap of at least TURN_CYCLES cycles SHALL separate them.
REQ-023 oOwner SHALL be updated on the same edge as oGnt.

Reset
REQ-024 While iRst_n is low, state SHALL be IDLE, oGnt, oEna, oOwner and oBusy SHALL be 0, ptr SHALL be 0 and hcnt SHALL be 0, independent of iClk.
REQ-025 Reset asserted mid-tenure SHALL drop oEna to 0 immediately, without waiting for a clock edge.
REQ-026 After iRst_n rises, the first arbitration SHALL occur on the first rising iClk edge.

Structure
REQ-027 Package tri_bus_pkg SHALL hold the state encoding (IDLE=0, GRANT=1, TURN=2) and the default constants N, MAX_HOLD and TURN_CYCLES.
REQ-028 Round-robin selection SHALL be a combinational sub-module rr_pick (inputs: req, ptr; outputs: one-hot gnt, index, valid), instantiated once.
REQ-029 All outputs SHALL come directly from flip-flops.

Verification
REQ-030 Single request: iReq=0001 at cycle 2 -> oGnt=0001 at cycle 3 and oOwner=0; iReq=0 at cycle 6 -> oGnt=0000 from cycle 7 for 1 cycle, then IDLE.
REQ-031 Round-robin: iReq=1111 held -> grant order 0,1,2,3,0; each tenure is 8 cycles, followed by 1 zero cycle.
REQ-032 Expiry fairness: iReq=0011 held, owner 0 -> owner 0 released after 8 cycles, 1 dead cycle, then oGnt=0010.
REQ-033 Simultaneous drop and expiry: iReq[owner] falls on the cycle where hcnt=7 -> exactly one TURN cycle, no double transition.
REQ-034 Reset mid-operation: iRst_n low during GRANT between edges -> oEna=0000 within the same cycle; ptr=0 after release.
REQ-035 Checker, run throughout all tests: popcount(oEna) is at most 1, and no cycle has oEna going from a nonzero value to a different nonzero value.

Source files
------------

// File: rtl/tri_bus_pkg.sv
// Shared types and default constants for the tri-state bus arbiter.
// The helper wraps a round-robin candidate index back into 0..n-1.
package tri_bus_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } state_t;

  localparam int DEF_N           = 4;
  localparam int DEF_MAX_HOLD    = 8;
  localparam int DEF_TURN_CYCLES = 1;

  function automatic int wrap_idx(input int base, input int off, input int n);
    return (base + off) % n;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: the first requesting index at or after
// ptr, wrapping from N-1 back to 0.
module rr_pick
  import tri_bus_pkg::*;
#(
  parameter int N  = DEF_N,
  parameter int IW = $clog2(DEF_N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] index,
  output logic          valid
);

  logic [IW-1:0] w_cand [N];

  for (genvar i = 0; i < N; i++) begin : g_cand
    assign w_cand[i] = IW'(wrap_idx(int'(ptr), i, N));
  end

  always_comb begin
    // NOTE: every output gets a default before the loop, so no path can infer a latch.
    gnt   = '0;
    index = '0;
    valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!valid && req[w_cand[i]]) begin
        valid           = 1'b1;
        index           = w_cand[i];
        gnt[w_cand[i]]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tri_bus_arbiter.sv
// Round-robin arbiter for a shared tri-state bus: bounded tenures separated by
// dead turnaround cycles, with registered one-hot grants and driver enables.
module tri_bus_arbiter
  import tri_bus_pkg::*;
#(
  parameter int N           = DEF_N,
  parameter int MAX_HOLD    = DEF_MAX_HOLD,
  parameter int TURN_CYCLES = DEF_TURN_CYCLES
) (
  input  logic                 iClk,
  input  logic                 iRst_n,
  input  logic [N-1:0]         iReq,
  output logic [N-1:0]         oGnt,
  output logic [N-1:0]         oEna,
  output logic [$clog2(N)-1:0] oOwner,
  output logic                 oBusy
);

  localparam int IW = $clog2(N);
  localparam int HW = $clog2(MAX_HOLD) + 1;
  localparam int TW = $clog2(TURN_CYCLES) + 1;

  state_t        r_state, w_state_nxt;
  logic [N-1:0]  r_gnt, w_gnt_nxt;
  logic [IW-1:0] r_owner, w_owner_nxt;
  logic [IW-1:0] r_ptr, w_ptr_nxt;
  logic [HW-1:0] r_hcnt, w_hcnt_nxt;
  logic [TW-1:0] r_tcnt, w_tcnt_nxt;
  logic          r_busy, w_busy_nxt;

  logic [N-1:0]  w_pick_gnt;
  logic [IW-1:0] w_pick_idx;
  logic          w_pick_valid;
  logic          w_exit, w_turn_done, w_arb;
  logic [IW-1:0] w_ptr_inc;

  rr_pick #(.N(N), .IW(IW)) u_rr_pick (
    .req   (iReq),
    .ptr   (r_ptr),
    .gnt   (w_pick_gnt),
    .index (w_pick_idx),
    .valid (w_pick_valid)
  );

  // A tenure ends when its owner lets go or has used its full hold budget.
  assign w_exit      = !iReq[r_owner] || (r_hcnt == HW'(MAX_HOLD - 1));
  assign w_turn_done = (r_tcnt == TW'(TURN_CYCLES - 1));
  assign w_arb       = (r_state == IDLE) || ((r_state == TURN) && w_turn_done);
  assign w_ptr_inc   = (r_owner == IW'(N - 1)) ? '0 : r_owner + IW'(1);

  always_ff @(posedge iClk or negedge iRst_n) begin
    // NOTE: async clear drops the enables the moment reset asserts; non-blocking
    // assignments keep every register sampling pre-edge values.
    if (!iRst_n) begin
      r_state <= IDLE;
      r_gnt   <= '0;
      r_owner <= '0;
      r_ptr   <= '0;
      r_hcnt  <= '0;
      r_tcnt  <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      r_owner <= w_owner_nxt;
      r_ptr   <= w_ptr_nxt;
      r_hcnt  <= w_hcnt_nxt;
      r_tcnt  <= w_tcnt_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_pick_valid) w_state_nxt = GRANT;
      GRANT:   if (w_exit) w_state_nxt = TURN;
      TURN:    if (w_turn_done) w_state_nxt = w_pick_valid ? GRANT : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_gnt_nxt   = r_gnt;
    w_owner_nxt = r_owner;
    w_ptr_nxt   = r_ptr;
    w_hcnt_nxt  = r_hcnt;
    w_tcnt_nxt  = r_tcnt;
    w_busy_nxt  = (w_state_nxt != IDLE);
    if (w_arb) begin
      w_gnt_nxt   = w_pick_valid ? w_pick_gnt : '0;
      w_owner_nxt = w_pick_valid ? w_pick_idx : '0;
      w_hcnt_nxt  = '0;
    end else if (r_state == GRANT) begin
      if (w_exit) begin
        w_gnt_nxt   = '0;
        w_owner_nxt = '0;
        w_ptr_nxt   = w_ptr_inc;
        w_tcnt_nxt  = '0;
      end else begin
        w_hcnt_nxt = r_hcnt + HW'(1);
      end
    end else if (r_state == TURN) begin
      w_tcnt_nxt = r_tcnt + TW'(1);
    end
  end

  assign oGnt   = r_gnt;
  assign oEna   = r_gnt;
  assign oOwner = r_owner;
  assign oBusy  = r_busy;

endmodule
